eeprom_frame_loader: RTL and testbench

//  Sequences the EEPROM-side spi_send_receive engine to load one display frame.
//  On start: drops EEPROM CS, sends the READ opcode and address bytes, then reads FRAME_LEN data bytes.

---
 rtl/trexon_pkg.sv | 26 ++
 rtl/rise_detect.sv | 23 ++
 rtl/eeprom_frame_loader.sv | 167 ++++++++++++++++
 tb/tb_eeprom_frame_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trexon_pkg.sv
// Shared types and helpers for the EEPROM frame loader.
// Holds the loader state encoding, the read opcode and address byte selection.
package trexon_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMD  = 3'd1,
        ADDR = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } state_e;

    localparam logic [7:0] EEPROM_READ_OPCODE = 8'h03;

    // Byte idx of an nbytes-wide address, MSB first.
    function automatic logic [7:0] addr_byte(input logic [23:0] addr,
                                             input int unsigned nbytes,
                                             input logic [7:0]  idx);
        logic [23:0] shifted;
        int unsigned sh;
        sh      = (nbytes - 32'(idx) - 32'd1) * 32'd8;
        shifted = addr >> sh;
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input.
// The delayed copy keeps tracking while its consumer ignores the pulse.
module rise_detect (
    input  logic clk,
    input  logic nreset,
    input  logic d,
    output logic rise
);

    logic dly_r;

    // One-cycle delayed copy of d.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            dly_r <= 1'b0;
        end else begin
            dly_r <= d;
        end
    end

    assign rise = d & ~dly_r;

endmodule

// File: rtl/eeprom_frame_loader.sv
// Drives the EEPROM-side SPI engine through READ opcode, address and FRAME_LEN data bytes,
// handing each received data byte to the shift register with a one-cycle shift pulse.
module eeprom_frame_loader
    import trexon_pkg::*;
#(
    parameter int unsigned FRAME_LEN   = 100,
    parameter int unsigned ADDR_BYTES  = 1,
    parameter logic [23:0] START_ADDR  = 24'h0,
    parameter logic [7:0]  READ_OPCODE = EEPROM_READ_OPCODE
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       spi_send_request,
    output logic [7:0] spi_din,
    output logic       spi_cs_at_end,
    input  logic       spi_processing,
    input  logic       spi_data_valid,
    input  logic [7:0] spi_dout,
    output logic       eeprom_cs,
    output logic [7:0] sr_data,
    output logic       sr_shift
);

    localparam logic [7:0] FRAME_LAST = 8'(FRAME_LEN - 32'd1);
    localparam logic [7:0] ADDR_LAST  = 8'((ADDR_BYTES == 32'd0) ? 32'd0 : ADDR_BYTES - 32'd1);
    localparam state_e     AFTER_CMD  = (ADDR_BYTES == 32'd0) ? DATA : ADDR;

    state_e     state_r, state_s;
    logic [7:0] byte_idx_r, byte_idx_s;
    logic       pending_r, pending_s;
    logic       busy_r, done_r, done_s, aborted_r, aborted_s;
    logic       req_r, req_s, cs_r, cs_s, shift_r, shift_s;
    logic [7:0] din_r, din_s, sr_data_r, sr_data_s;
    logic       rise_s;

    rise_detect u_valid_rise (
        .clk    (clk),
        .nreset (nreset),
        .d      (spi_data_valid),
        .rise   (rise_s)
    );

    // Next-state, counters and next output values; abort outranks completion and issue.
    always_comb begin
        state_s    = state_r;
        byte_idx_s = byte_idx_r;
        pending_s  = pending_r;
        req_s      = 1'b0;
        din_s      = din_r;
        cs_s       = cs_r;
        sr_data_s  = sr_data_r;
        shift_s    = 1'b0;
        done_s     = 1'b0;
        aborted_s  = 1'b0;
        if (state_r == IDLE) begin
            if (start && !abort) begin
                state_s    = CMD;
                cs_s       = 1'b0;
                byte_idx_s = 8'd0;
                pending_s  = 1'b0;
            end else begin
                cs_s = 1'b1;
            end
        end else if (abort) begin
            state_s    = IDLE;
            cs_s       = 1'b1;
            aborted_s  = 1'b1;
            pending_s  = 1'b0;
            byte_idx_s = 8'd0;
        end else if (state_r == DONE) begin
            state_s = IDLE;
            done_s  = 1'b1;
        end else if (rise_s) begin
            // A completed byte never triggers a new request in the same cycle.
            pending_s = 1'b0;
            case (state_r)
                CMD: begin
                    state_s    = AFTER_CMD;
                    byte_idx_s = 8'd0;
                end
                ADDR: begin
                    if (byte_idx_r == ADDR_LAST) begin
                        state_s    = DATA;
                        byte_idx_s = 8'd0;
                    end else begin
                        byte_idx_s = byte_idx_r + 8'd1;
                    end
                end
                DATA: begin
                    sr_data_s = spi_dout;
                    shift_s   = 1'b1;
                    if (byte_idx_r == FRAME_LAST) begin
                        state_s = DONE;
                        cs_s    = 1'b1;
                    end else begin
                        byte_idx_s = byte_idx_r + 8'd1;
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else if (!pending_r && !spi_processing) begin
            req_s     = 1'b1;
            pending_s = 1'b1;
            case (state_r)
                CMD:     din_s = READ_OPCODE;
                ADDR:    din_s = addr_byte(START_ADDR, ADDR_BYTES, byte_idx_r);
                default: din_s = 8'h00;
            endcase
        end else begin
            pending_s = pending_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Counters, pending flag and registered outputs.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            byte_idx_r <= 8'd0;
            pending_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            aborted_r  <= 1'b0;
            req_r      <= 1'b0;
            din_r      <= 8'h00;
            cs_r       <= 1'b1;
            sr_data_r  <= 8'h00;
            shift_r    <= 1'b0;
        end else begin
            byte_idx_r <= byte_idx_s;
            pending_r  <= pending_s;
            busy_r     <= (state_s != IDLE);
            done_r     <= done_s;
            aborted_r  <= aborted_s;
            req_r      <= req_s;
            din_r      <= din_s;
            cs_r       <= cs_s;
            sr_data_r  <= sr_data_s;
            shift_r    <= shift_s;
        end
    end

    assign busy             = busy_r;
    assign done             = done_r;
    assign aborted          = aborted_r;
    assign spi_send_request = req_r;
    assign spi_din          = din_r;
    assign spi_cs_at_end    = 1'b0;
    assign eeprom_cs        = cs_r;
    assign sr_data          = sr_data_r;
    assign sr_shift         = shift_r;

endmodule

// File: tb/tb_eeprom_frame_loader.sv
// Bench for eeprom_frame_loader: two instances (default and 2-byte-address/4-byte frame)
// each driven by a behavioural SPI engine returning random bytes.
module tb_eeprom_frame_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic nreset = 1'b0;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic start_a = 1'b0, abort_a = 1'b0, busy_a, done_a, aborted_a, req_a, cse_a, cs_a, shift_a;
    logic proc_a = 1'b0, valid_a = 1'b0;
    logic [7:0] din_a, srd_a, dout_a = 8'h00;
    logic start_b = 1'b0, abort_b = 1'b0, busy_b, done_b, aborted_b, req_b, cse_b, cs_b, shift_b;
    logic proc_b = 1'b0, valid_b = 1'b0;
    logic [7:0] din_b, srd_b, dout_b = 8'h00;

    eeprom_frame_loader dut_a (
        .clk(clk), .nreset(nreset), .start(start_a), .abort(abort_a), .busy(busy_a),
        .done(done_a), .aborted(aborted_a), .spi_send_request(req_a), .spi_din(din_a),
        .spi_cs_at_end(cse_a), .spi_processing(proc_a), .spi_data_valid(valid_a),
        .spi_dout(dout_a), .eeprom_cs(cs_a), .sr_data(srd_a), .sr_shift(shift_a)
    );

    eeprom_frame_loader #(.FRAME_LEN(4), .ADDR_BYTES(2), .START_ADDR(24'h001234)) dut_b (
        .clk(clk), .nreset(nreset), .start(start_b), .abort(abort_b), .busy(busy_b),
        .done(done_b), .aborted(aborted_b), .spi_send_request(req_b), .spi_din(din_b),
        .spi_cs_at_end(cse_b), .spi_processing(proc_b), .spi_data_valid(valid_b),
        .spi_dout(dout_b), .eeprom_cs(cs_b), .sr_data(srd_b), .sr_shift(shift_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // SPI engine models: 18 cycles processing, then data_valid for 2 cycles with a random byte.
    int pcnt_a = 0, vcnt_a = 0, pcnt_b = 0, vcnt_b = 0;
    logic [7:0] nxt_a, nxt_b;
    logic [7:0] rsp_a[$], rsp_b[$];

    always @(posedge clk) begin
        if (req_a && pcnt_a == 0 && vcnt_a == 0) begin
            proc_a <= 1'b1; pcnt_a <= 18;
        end else if (pcnt_a > 0) begin
            pcnt_a <= pcnt_a - 1;
            if (pcnt_a == 1) begin
                nxt_a = 8'($urandom);
                rsp_a.push_back(nxt_a);
                proc_a <= 1'b0; valid_a <= 1'b1; vcnt_a <= 2; dout_a <= nxt_a;
            end
        end else if (vcnt_a > 0) begin
            vcnt_a <= vcnt_a - 1;
            if (vcnt_a == 1) valid_a <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (req_b && pcnt_b == 0 && vcnt_b == 0) begin
            proc_b <= 1'b1; pcnt_b <= 18;
        end else if (pcnt_b > 0) begin
            pcnt_b <= pcnt_b - 1;
            if (pcnt_b == 1) begin
                nxt_b = 8'($urandom);
                rsp_b.push_back(nxt_b);
                proc_b <= 1'b0; valid_b <= 1'b1; vcnt_b <= 2; dout_b <= nxt_b;
            end
        end else if (vcnt_b > 0) begin
            vcnt_b <= vcnt_b - 1;
            if (vcnt_b == 1) valid_b <= 1'b0;
        end
    end

    // Monitors: log requested bytes, shifted bytes, pulses and chip-select misuse.
    logic [7:0] dq_a[$], sq_a[$], dq_b[$], sq_b[$];
    int done_cnt_a = 0, ab_cnt_a = 0, csbad_a = 0, dcyc_a = 0, lsh_a = 0;
    int done_cnt_b = 0, ab_cnt_b = 0, csbad_b = 0, dcyc_b = 0, lsh_b = 0;
    logic vprev_a = 1'b0, vprev_b = 1'b0;

    always @(negedge clk) begin
        if (req_a) begin dq_a.push_back(din_a); if (cs_a) csbad_a++; end
        if (valid_a && !vprev_a && busy_a && cs_a) csbad_a++;
        vprev_a = valid_a;
        if (shift_a) begin sq_a.push_back(srd_a); lsh_a = cyc; end
        if (done_a) begin done_cnt_a++; dcyc_a = cyc; end
        if (aborted_a) ab_cnt_a++;
        if (req_b) begin dq_b.push_back(din_b); if (cs_b) csbad_b++; end
        if (valid_b && !vprev_b && busy_b && cs_b) csbad_b++;
        vprev_b = valid_b;
        if (shift_b) begin sq_b.push_back(srd_b); lsh_b = cyc; end
        if (done_b) begin done_cnt_b++; dcyc_b = cyc; end
        if (aborted_b) ab_cnt_b++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected byte k sent on SPI: opcode, address bytes MSB first, then dummy zeros.
    function automatic logic [7:0] exp_din(input int k, input int abytes, input logic [23:0] addr);
        logic [23:0] v;
        if (k == 0) return 8'h03;
        else if (k <= abytes) begin
            v = (addr >> (8 * (abytes - k))) & 24'h0000FF;
            return v[7:0];
        end else return 8'h00;
    endfunction

    task automatic clear_logs();
        dq_a.delete(); sq_a.delete(); rsp_a.delete();
        done_cnt_a = 0; ab_cnt_a = 0; csbad_a = 0;
        dq_b.delete(); sq_b.delete(); rsp_b.delete();
        done_cnt_b = 0; ab_cnt_b = 0; csbad_b = 0;
    endtask

    task automatic wait_done(input int u, input int budget);
        int d0, n;
        d0 = (u == 0) ? done_cnt_a : done_cnt_b;
        n = 0;
        while (((u == 0) ? done_cnt_a : done_cnt_b) == d0 && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check_eq("done_timeout", (u == 0) ? done_cnt_a : done_cnt_b, d0 + 1);
    endtask

    task automatic wait_shifts_a(input int target, input int budget);
        int n;
        n = 0;
        while (sq_a.size() < target && n < budget) begin tick(); n++; end
        if (n >= budget) check_eq("shift_timeout", sq_a.size(), target);
    endtask

    task automatic wait_spi_idle();
        int n;
        n = 0;
        while ((proc_a || valid_a || pcnt_a != 0 || vcnt_a != 0) && n < 100) begin tick(); n++; end
        if (n >= 100) check_eq("spi_idle_timeout", pcnt_a + vcnt_a, 0);
    endtask

    task automatic check_load(input int u, input int abytes, input logic [23:0] addr, input int flen);
        logic [7:0] dq[$], sq[$], rq[$];
        int dc, dcy, lsc, csb;
        if (u == 0) begin
            dq = dq_a; sq = sq_a; rq = rsp_a; dc = done_cnt_a; dcy = dcyc_a; lsc = lsh_a; csb = csbad_a;
        end else begin
            dq = dq_b; sq = sq_b; rq = rsp_b; dc = done_cnt_b; dcy = dcyc_b; lsc = lsh_b; csb = csbad_b;
        end
        check_eq("din_count", dq.size(), flen + abytes + 1);
        for (int k = 0; k < dq.size() && k < flen + abytes + 1; k++)
            check_eq($sformatf("din[%0d]", k), dq[k], exp_din(k, abytes, addr));
        check_eq("shift_count", sq.size(), flen);
        for (int k = 0; k < sq.size(); k++)
            if (1 + abytes + k < rq.size())
                check_eq($sformatf("sr_data[%0d]", k), sq[k], rq[1 + abytes + k]);
        check_eq("done_count", dc, 1);
        check_eq("done_latency", dcy, lsc + 1);
        check_eq("cs_low_during_xfer", csb, 0);
    endtask

    initial begin
        int gap;
        // Reset state
        repeat (3) tick();
        check_eq("rst_cs", cs_a, 1'b1);
        check_eq("rst_busy", busy_a, 1'b0);
        check_eq("rst_pulses", {done_a, aborted_a, req_a, shift_a, cse_a}, 5'b0);
        check_eq("rst_data", {din_a, srd_a}, 16'h0);
        check_eq("rst_cs_b", cs_b, 1'b1);
        nreset = 1'b1;
        repeat (2) tick();

        // 1: nominal default load
        clear_logs();
        start_a = 1'b1; tick(); start_a = 1'b0;
        check_eq("t1_busy", busy_a, 1'b1);
        check_eq("t1_cs_low", cs_a, 1'b0);
        wait_done(0, 4000);
        tick();
        check_load(0, 1, 24'h0, 100);
        check_eq("t1_busy_after", busy_a, 1'b0);
        check_eq("t1_cs_after", cs_a, 1'b1);

        // 2: two address bytes, 4-byte frame
        clear_logs();
        start_b = 1'b1; tick(); start_b = 1'b0;
        wait_done(1, 1000);
        tick();
        check_load(1, 2, 24'h001234, 4);
        check_eq("t2_busy_after", busy_b, 1'b0);

        // 3: abort during the 38th data byte
        clear_logs();
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_shifts_a(37, 4000);
        gap = $urandom_range(2, 10);
        repeat (gap) tick();
        abort_a = 1'b1; tick(); abort_a = 1'b0;
        check_eq("t3_aborted", aborted_a, 1'b1);
        check_eq("t3_cs", cs_a, 1'b1);
        check_eq("t3_busy", busy_a, 1'b0);
        check_eq("t3_no_done", done_a, 1'b0);
        repeat (40) tick();
        check_eq("t3_shifts", sq_a.size(), 37);
        check_eq("t3_done_cnt", done_cnt_a, 0);
        check_eq("t3_abort_cnt", ab_cnt_a, 1);
        for (int k = 0; k < sq_a.size() && k + 2 < rsp_a.size(); k++)
            check_eq($sformatf("t3_sr_data[%0d]", k), sq_a[k], rsp_a[k + 2]);
        wait_spi_idle();

        // 4: start held high -> immediate reload; start pulse while busy is ignored
        clear_logs();
        start_a = 1'b1;
        wait_done(0, 4000);
        check_eq("t4_first_shifts", sq_a.size(), 100);
        check_eq("t4_restart_busy", busy_a, 1'b1);
        check_eq("t4_restart_cs", cs_a, 1'b0);
        start_a = 1'b0;
        clear_logs();
        wait_shifts_a(50, 4000);
        start_a = 1'b1; tick(); start_a = 1'b0;
        wait_done(0, 4000);
        tick();
        check_load(0, 1, 24'h0, 100);
        wait_spi_idle();

        // 5: reset mid-ADDR, then a stale data_valid rise
        clear_logs();
        start_a = 1'b1; tick(); start_a = 1'b0;
        gap = 0;
        while (dq_a.size() < 2 && gap < 200) begin tick(); gap++; end
        check_eq("t5_in_addr", dq_a.size(), 2);
        nreset = 1'b0; tick();
        check_eq("t5_cs", cs_a, 1'b1);
        check_eq("t5_busy", busy_a, 1'b0);
        check_eq("t5_pulses", {done_a, aborted_a, req_a, shift_a}, 4'b0);
        nreset = 1'b1;
        repeat (40) tick();
        check_eq("t5_no_shift", sq_a.size(), 0);
        check_eq("t5_no_req", dq_a.size(), 2);
        check_eq("t5_no_pulse", done_cnt_a + ab_cnt_a, 0);
        wait_spi_idle();

        // 6: start and abort together in IDLE
        clear_logs();
        start_a = 1'b1; abort_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq("t6_busy", busy_a, 1'b0);
        end
        start_a = 1'b0; abort_a = 1'b0;
        tick();
        check_eq("t6_aborted", ab_cnt_a, 0);
        check_eq("t6_no_req", dq_a.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
